// File: rtl/apb_demux_pkg.sv
// Shared types and helpers for the APB round-robin master sequencer.
package apb_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned RDATA_ZERO = 0;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module apb_rr_arbiter
    import apb_demux_pkg::*;
#(
    parameter int unsigned REQ_COUNT = 4,
    localparam int unsigned IW = idx_width(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] valid,
    input  logic [IW-1:0]        ptr,
    output logic [REQ_COUNT-1:0] grant,
    output logic [IW-1:0]        grant_idx,
    output logic                 any_valid
);

    always_comb begin
        int unsigned k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            k = (32'(ptr) + i) % REQ_COUNT;
            if (!any_valid && valid[k]) begin
                any_valid = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter plus APB master sequencer sharing one APB port among REQ_COUNT requesters.
module apb_rr_master_arb
    import apb_demux_pkg::*;
#(
    parameter int unsigned REQ_COUNT      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [REQ_COUNT-1:0]             req_valid_i,
    output logic [REQ_COUNT-1:0]             req_ready_o,
    input  logic [REQ_COUNT*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [REQ_COUNT-1:0]             req_write_i,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0]  req_wdata_i,
    output logic [REQ_COUNT-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic                             PREADY,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PSLVERR
);

    localparam int unsigned IW = idx_width(REQ_COUNT);
    localparam int unsigned CW = idx_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(REQ_COUNT - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = DATA_WIDTH'(RDATA_ZERO);

    apb_state_e            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         owner;
    logic [CW-1:0]         cnt;
    logic [REQ_COUNT-1:0]  grant;
    logic [IW-1:0]         gidx;
    logic                  any_valid;
    logic                  complete;
    logic                  do_grant;

    apb_rr_arbiter #(
        .REQ_COUNT (REQ_COUNT)
    ) u_arb (
        .valid     (req_valid_i),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx),
        .any_valid (any_valid)
    );

    // A stalled slave is cut off on the last allowed ACCESS cycle.
    assign complete    = (state == ST_ACCESS) && (PREADY || (cnt == CNT_LAST));
    assign do_grant    = PRESETn && any_valid && ((state == ST_IDLE) || complete);
    assign req_ready_o = do_grant ? grant : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;

            if (complete) begin
                rsp_valid_o <= REQ_COUNT'(1) << owner;
                rsp_rdata_o <= (PREADY && !PWRITE) ? PRDATA : ZERO_DATA;
                rsp_err_o   <= PREADY ? PSLVERR : 1'b1;
            end

            // Capture the winner's fields on the grant edge; they hold until the next grant.
            if (do_grant) begin
                state   <= ST_SETUP;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                owner   <= gidx;
                ptr     <= (gidx == IDX_LAST) ? '0 : gidx + IW'(1);
                PADDR   <= req_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                PWRITE  <= req_write_i[gidx];
                PWDATA  <= req_write_i[gidx] ? req_wdata_i[gidx*DATA_WIDTH +: DATA_WIDTH]
                                             : ZERO_DATA;
            end else begin
                case (state)
                    ST_IDLE: begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                    ST_SETUP: begin
                        state   <= ST_ACCESS;
                        PENABLE <= 1'b1;
                        cnt     <= '0;
                    end
                    ST_ACCESS: begin
                        if (complete) begin
                            state   <= ST_IDLE;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Randomized scoreboard bench for apb_rr_master_arb against a transaction-level reference model.
module tb_apb_rr_master_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*AW-1:0]   req_addr_i;
    logic [N-1:0]      req_write_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N-1:0]      rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    apb_rr_master_arb #(
        .REQ_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int           due;
        logic [N-1:0] vld;
        logic [DW-1:0] rdata;
        logic         err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    // Reference model: phase 0 idle, 1 setup, 2 access (transfer-level view)
    int            mphase, mcnt, mowner, mptr, win, k;
    logic          cmpl;
    logic [N-1:0]  er, acc_mask;
    logic [AW-1:0] maddr;
    logic          mwrite;
    logic [DW-1:0] mwdata;

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            mphase = 0; mcnt = 0; mptr = 0; mowner = 0;
            acc_mask = '0;
            exp_q.delete();
        end else begin
            cmpl = (mphase == 2) && (PREADY || mcnt == TO - 1);
            win  = -1;
            if (mphase == 0 || cmpl) begin
                for (int i = 0; i < N; i++) begin
                    k = (mptr + i) % N;
                    if (win < 0 && req_valid_i[k]) win = k;
                end
            end
            er = (win >= 0) ? (N'(1) << win) : '0;
            check("req_ready", req_ready_o, er);
            acc_mask = req_ready_o;
            check("psel", PSEL, mphase != 0);
            check("penable", PENABLE, mphase == 2);
            if (mphase != 0) begin
                check("paddr", PADDR, maddr);
                check("pwrite", PWRITE, mwrite);
                check("pwdata", PWDATA, mwdata);
            end
            if (cmpl)
                exp_q.push_back('{cyc + 1, N'(1) << mowner,
                                  (PREADY && !mwrite) ? PRDATA : '0,
                                  PREADY ? PSLVERR : 1'b1});
            if (win >= 0) begin
                maddr  = req_addr_i[win*AW +: AW];
                mwrite = req_write_i[win];
                mwdata = req_write_i[win] ? req_wdata_i[win*DW +: DW] : '0;
                mowner = win;
                mptr   = (win + 1) % N;
                mphase = 1;
            end else if (mphase == 1) begin
                mphase = 2;
                mcnt   = 0;
            end else if (mphase == 2) begin
                if (cmpl) mphase = 0;
                else      mcnt++;
            end
        end
    end

    // Response monitor
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid_o, '0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_cycle", cyc, mon_e.due);
                    check("rsp_valid", rsp_valid_o, mon_e.vld);
                    check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                    check("rsp_err", rsp_err_o, mon_e.err);
                end
            end else begin
                check("rsp_rdata_idle", rsp_rdata_o, '0);
                check("rsp_err_idle", rsp_err_o, 1'b0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_missing", rsp_valid_o, mon_e.vld);
                end
            end
        end
    end

    task automatic step(input int p_req, input int p_rdy, input int p_err);
        @(posedge PCLK); #1;
        for (int r = 0; r < N; r++) begin
            if (acc_mask[r]) req_valid_i[r] = 1'b0;
            if (!req_valid_i[r] && $urandom_range(99) < p_req) begin
                req_valid_i[r]          = 1'b1;
                req_addr_i[r*AW +: AW]  = $urandom & 32'h0000_FFFC;
                req_write_i[r]          = 1'($urandom_range(1));
                req_wdata_i[r*DW +: DW] = $urandom;
            end
        end
        PREADY  = $urandom_range(99) < p_rdy;
        PRDATA  = $urandom;
        PSLVERR = $urandom_range(99) < p_err;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"}, PSEL, 1'b0);
        check({tag, "_penable"}, PENABLE, 1'b0);
        check({tag, "_paddr"}, PADDR, '0);
        check({tag, "_pwrite"}, PWRITE, 1'b0);
        check({tag, "_pwdata"}, PWDATA, '0);
        check({tag, "_rsp_valid"}, rsp_valid_o, '0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, '0);
        check({tag, "_rsp_err"}, rsp_err_o, 1'b0);
        check({tag, "_req_ready"}, req_ready_o, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        PRESETn     = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_write_i = '0;
        req_wdata_i = '0;
        PREADY      = 1'b0;
        PRDATA      = '0;
        PSLVERR     = 1'b0;
        acc_mask    = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check_all_zero("reset");
        PRESETn = 1'b1;

        // Single read from requester 1 at 0x40 with an immediately ready slave
        req_valid_i[1]        = 1'b1;
        req_addr_i[1*AW +: AW] = 32'h40;
        req_write_i[1]        = 1'b0;
        PREADY  = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        PSLVERR = 1'b0;
        repeat (6) begin
            @(posedge PCLK); #1;
            req_valid_i = req_valid_i & ~acc_mask;
        end

        repeat (300) step(40, 60, 20);
        repeat (100) step(100, 100, 10);
        repeat (80)  step(60, 0, 0);

        // Reset in the middle of a stalled ACCESS
        guard = 0;
        while (!(mphase == 2 && mcnt == 3) && guard < 100) begin
            step(60, 0, 0);
            guard++;
        end
        check("reach_access_for_reset", guard < 100, 1'b1);
        @(posedge PCLK); #1;
        PRESETn     = 1'b0;
        req_valid_i = 4'b1000;
        req_addr_i[3*AW +: AW]  = 32'h0000_0300;
        req_write_i[3]          = 1'b1;
        req_wdata_i[3*DW +: DW] = 32'h1234_5678;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        #1;
        check("first_grant_after_reset", req_ready_o, 4'b1000);

        repeat (300) step(70, 70, 20);
        repeat (60)  step(0, 100, 0);
        check("queue_drained", exp_q.size(), 0);
        check("requests_drained", req_valid_i, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
Round-robin arbiter and APB master sequencer that lets REQ_COUNT internal requesters share the single APB master port feeding the APB address demux.
- Accepts one request at a time over a valid/ready handshake.
- Runs the APB SETUP/ACCESS protocol and returns read data and error status to the winning requester.
- A per-transfer timeout guarantees forward progress if the addressed slave never asserts PREADY.

Parameters:
REQ_COUNT, 4, number of requesters (>=2)
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced error completion (>=2)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req_valid_i  in  REQ_COUNT  per-requester request valid; held with fields stable until req_ready_o
req_ready_o  out  REQ_COUNT  one-hot grant/accept pulse (combinational)
req_addr_i  in  REQ_COUNT*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write_i  in  REQ_COUNT  1=write
req_wdata_i  in  REQ_COUNT*DATA_WIDTH  packed write data
rsp_valid_o  out  REQ_COUNT  one-hot completion pulse, registered
rsp_rdata_o  out  DATA_WIDTH  read data of completed transfer (0 for writes)
rsp_err_o  out  1  PSLVERR or timeout, valid with rsp_valid_o
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  APB ready
PRDATA  in  DATA_WIDTH  APB read data
PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: single clock PCLK. Asynchronous active-low reset PRESETn.
- Reset values:
  - state=IDLE; all APB outputs 0; rsp_* 0.
  - rr pointer=0; timeout counter=0.
  - req_ready_o=0.
  - A reset mid-transfer aborts it with no response.
- Arbitration:
  - Combinational round-robin.
  - Search order starts at rr pointer and wraps modulo REQ_COUNT.
  - Winner = first requester with valid=1.
  - On a grant, rr pointer <= winner+1, wrapping REQ_COUNT-1 -> 0.
- Grant points: only in IDLE, or in ACCESS on the completion cycle.
  - req_ready_o[winner]=1 for exactly that cycle; all other bits 0.
  - PADDR/PWRITE/PWDATA are registered from the winner's fields on the same edge.
  - PWDATA <= 0 for reads.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. If any valid: grant, go to SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS. Timeout counter cleared.
  - ACCESS: PSEL=1, PENABLE=1; counter increments each cycle PREADY=0.
    - Completion occurs when PREADY=1, or when counter==TIMEOUT_CYCLES-1 with PREADY=0.
    - On completion, if any valid: grant and go to SETUP (back-to-back; PENABLE drops, PSEL stays 1).
    - Otherwise go to IDLE.
- Response:
  - On the edge after completion, rsp_valid_o[owner]=1 for one cycle.
  - rsp_rdata_o=PRDATA if read and not timeout, else 0.
  - rsp_err_o = PSLVERR if PREADY completed, 1 if timeout.
  - rsp_rdata_o and rsp_err_o return to 0 when rsp_valid_o=0.
- Owner register: holds the index of the in-flight requester and is used for rsp_valid_o.
- A requester may raise req_valid_i again in its own completion cycle. It competes normally and cannot win twice in a row while others are pending.
- APB outputs stay stable for the whole SETUP+ACCESS of one transfer.
- Minimum throughput: one transfer per 2 cycles with PREADY=1 and continuous requests.

Decomposition:
- Package apb_demux_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - function clog2-based index width;
  - constant for the zero read-data value.
- One sub-module apb_rr_arbiter: REQ_COUNT-wide round-robin picker.
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational.

Test Plan:
- Single read, req 1 at addr 0x40, PREADY high immediately:
  - SETUP next cycle, ACCESS the following cycle.
  - rsp_valid_o=4'b0010 with PRDATA 0xDEADBEEF, rsp_err_o=0.
- All 4 requesters valid continuously, PREADY=1:
  - grant order 0,1,2,3,0.
  - PSEL stays 1 throughout; PENABLE toggles each cycle.
  - 2 cycles per transfer.
- Write from req 2 with PSLVERR=1 and PREADY after 3 wait states:
  - PWDATA stable for 5 cycles.
  - rsp_valid_o[2]=1, rsp_err_o=1, rsp_rdata_o=0.
- PREADY held 0 with TIMEOUT_CYCLES=16:
  - ACCESS lasts exactly 16 cycles.
  - rsp_err_o=1, rsp_rdata_o=0.
  - FSM returns to IDLE.
- PRESETn asserted during ACCESS:
  - all outputs 0 immediately; no rsp_valid_o.
  - after release, pending req 3 is granted first because the pointer resets to 0 and req 0-2 are idle.
- Req 0 re-requests in its completion cycle while req 1 waits:
  - req 1 granted next, then req 0.
